// File: rtl/maxpool2x2_stage_if.sv
// Bundle between the conv stage (master) and the 2x2 pooling stage (slave).
// The master presents the feature map and start; the slave returns busy/done and the pooled map.
interface maxpool2x2_stage_if #(
   parameter int IN_SIZE   = 5,
   parameter int WIDTH_BIT = 8
);
   localparam int OUT_SIZE = IN_SIZE / 2;

   logic                        start;
   logic signed [WIDTH_BIT-1:0] inpMatrix [IN_SIZE][IN_SIZE];
   logic                        busy;
   logic                        done;
   logic signed [WIDTH_BIT-1:0] poolOut [OUT_SIZE][OUT_SIZE];

   modport master (
      output start, inpMatrix,
      input  busy, done, poolOut
   );

   modport slave (
      input  start, inpMatrix,
      output busy, done, poolOut
   );
endinterface

// File: rtl/maxpool2x2_stage.sv
// 2x2 / stride-2 pooling of a snapshot of the conv-stage feature map, one window per clock.
// Define MAXPOOL_AVG_EN to build average pooling instead of the default signed maximum.
module maxpool2x2_stage #(
   parameter int IN_SIZE   = 5,
   parameter int WIDTH_BIT = 8
) (
   input  logic              clock,
   input  logic              nreset,
   maxpool2x2_stage_if.slave bus
);
   localparam int OUT_SIZE = IN_SIZE / 2;
   localparam int CW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam logic [CW-1:0] LAST = CW'(OUT_SIZE - 1);

   // SETTLE separates the last window write from the done pulse.
   typedef enum logic [1:0] {IDLE, POOL, SETTLE, DONE} state_t;

   generate
      if (IN_SIZE < 2) begin : g_bad_size
         $error("maxpool2x2_stage: IN_SIZE must be at least 2");
      end
   endgenerate

   state_t                      state_q, state_d;
   logic [CW-1:0]               r_q, r_d, c_q, c_d;
   logic signed [WIDTH_BIT-1:0] snap_q  [IN_SIZE][IN_SIZE];
   logic signed [WIDTH_BIT-1:0] snap_d  [IN_SIZE][IN_SIZE];
   logic signed [WIDTH_BIT-1:0] pool_q  [OUT_SIZE][OUT_SIZE];
   logic signed [WIDTH_BIT-1:0] pool_d  [OUT_SIZE][OUT_SIZE];
   logic signed [WIDTH_BIT-1:0] win_res [OUT_SIZE][OUT_SIZE];
   logic                        last_win;

   function automatic logic signed [WIDTH_BIT-1:0] pool4(
      input logic signed [WIDTH_BIT-1:0] a,
      input logic signed [WIDTH_BIT-1:0] b,
      input logic signed [WIDTH_BIT-1:0] c,
      input logic signed [WIDTH_BIT-1:0] d
   );
`ifdef MAXPOOL_AVG_EN
      logic signed [WIDTH_BIT+1:0] sum;
      sum = (WIDTH_BIT+2)'(a) + (WIDTH_BIT+2)'(b) + (WIDTH_BIT+2)'(c) + (WIDTH_BIT+2)'(d);
      sum = sum >>> 2;
      return sum[WIDTH_BIT-1:0];
`else
      logic signed [WIDTH_BIT-1:0] m0;
      logic signed [WIDTH_BIT-1:0] m1;
      m0 = (a > b) ? a : b;
      m1 = (c > d) ? c : d;
      return (m0 > m1) ? m0 : m1;
`endif
   endfunction

   // Every window is evaluated in parallel; the counters pick which one lands.
   for (genvar gi = 0; gi < OUT_SIZE; gi++) begin : g_row
      for (genvar gj = 0; gj < OUT_SIZE; gj++) begin : g_col
         assign win_res[gi][gj] = pool4(snap_q[2*gi][2*gj],   snap_q[2*gi][2*gj+1],
                                        snap_q[2*gi+1][2*gj], snap_q[2*gi+1][2*gj+1]);
      end
   end

   assign last_win = (r_q == LAST) && (c_q == LAST);

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = POOL;
         POOL:    if (last_win)  state_d = SETTLE;
         SETTLE:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state_q != IDLE);
      bus.done = (state_q == DONE);
   end

   always_comb begin
      r_d    = r_q;
      c_d    = c_q;
      snap_d = snap_q;
      pool_d = pool_q;
      if (state_q == IDLE && bus.start) begin
         snap_d = bus.inpMatrix;
         r_d    = '0;
         c_d    = '0;
      end
      if (state_q == POOL) begin
         pool_d[r_q][c_q] = win_res[r_q][c_q];
         if (last_win) begin
            r_d = '0;
            c_d = '0;
         end else if (c_q == LAST) begin
            c_d = '0;
            r_d = r_q + 1'b1;
         end else begin
            c_d = c_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         r_q <= '0;
         c_q <= '0;
         for (int i = 0; i < IN_SIZE; i++) begin
            for (int j = 0; j < IN_SIZE; j++) begin
               snap_q[i][j] <= '0;
            end
         end
         for (int i = 0; i < OUT_SIZE; i++) begin
            for (int j = 0; j < OUT_SIZE; j++) begin
               pool_q[i][j] <= '0;
            end
         end
      end else begin
         r_q    <= r_d;
         c_q    <= c_d;
         snap_q <= snap_d;
         pool_q <= pool_d;
      end
   end

   assign bus.poolOut = pool_q;
endmodule
